// File: rtl/doorway_sensor_if.sv
// Beam inputs and passage event outputs of the doorway sensor.
// The slave side is the sensor; the master side drives the beams and observes the events.
interface doorway_sensor_if;
   logic outerBeam;
   logic innerBeam;
   logic entered;
   logic exited;
   logic fault;

   modport master (
      output outerBeam,
      output innerBeam,
      input  entered,
      input  exited,
      input  fault
   );

   modport slave (
      input  outerBeam,
      input  innerBeam,
      output entered,
      output exited,
      output fault
   );
endinterface

// File: rtl/doorway_sensor.sv
// Two-beam doorway sensor: synchronizes and debounces both beams, then tracks
// the beam order to emit one pulse per completed inward or outward passage.
//
// state | meaning
// IDLE  | both beams clear, no passage in progress
// O1    | outer beam only, entry started
// OB    | both beams blocked during entry
// I2    | inner beam only, entry finishing
// I1    | inner beam only, exit started
// IB    | both beams blocked during exit
// O2    | outer beam only, exit finishing
// ABORT | illegal order or timeout, waiting for both beams to clear
module doorway_sensor #(
   parameter int unsigned DEBOUNCE = 4,
   parameter int unsigned TIMEOUT  = 64
) (
   input  logic            clock,
   input  logic            reset,
   doorway_sensor_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE, O1, OB, I2, I1, IB, O2, ABORT
   } state_e;

   localparam logic [3:0] DB_LAST  = 4'(DEBOUNCE - 1);
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   logic [1:0]      outer_sync_q;
   logic [1:0]      inner_sync_q;
   logic [1:0]      sync_lvl;
   logic [1:0]      deb_q, deb_d;
   logic [1:0][3:0] db_cnt_q, db_cnt_d;
   state_e          state_q, state_d;
   logic [7:0]      tmo_q, tmo_d;
   logic            entered_q, entered_d;
   logic            exited_q, exited_d;
   logic            fault_q, fault_d;

   // bit 1 = outer, bit 0 = inner, so the debounced pair reads as (o,i)
   assign sync_lvl = {outer_sync_q[1], inner_sync_q[1]};

   always_comb begin
      for (int c = 0; c < 2; c++) begin
         deb_d[c]    = deb_q[c];
         db_cnt_d[c] = '0;
         if (sync_lvl[c] != deb_q[c]) begin
            if (db_cnt_q[c] == DB_LAST) begin
               deb_d[c] = sync_lvl[c];
            end else begin
               db_cnt_d[c] = db_cnt_q[c] + 4'd1;
            end
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      entered_d = 1'b0;
      exited_d  = 1'b0;
      case (state_q)
         IDLE: case (deb_q)
            2'b10:   state_d = O1;
            2'b01:   state_d = I1;
            2'b11:   state_d = ABORT;
            default: state_d = IDLE;
         endcase
         O1: case (deb_q)
            2'b11:   state_d = OB;
            2'b00:   state_d = IDLE;
            2'b01:   state_d = ABORT;
            default: state_d = O1;
         endcase
         OB: case (deb_q)
            2'b01:   state_d = I2;
            2'b10:   state_d = O1;
            2'b00:   state_d = ABORT;
            default: state_d = OB;
         endcase
         I2: case (deb_q)
            2'b00: begin
               state_d   = IDLE;
               entered_d = 1'b1;
            end
            2'b11:   state_d = OB;
            2'b10:   state_d = ABORT;
            default: state_d = I2;
         endcase
         I1: case (deb_q)
            2'b11:   state_d = IB;
            2'b00:   state_d = IDLE;
            2'b10:   state_d = ABORT;
            default: state_d = I1;
         endcase
         IB: case (deb_q)
            2'b10:   state_d = O2;
            2'b01:   state_d = I1;
            2'b00:   state_d = ABORT;
            default: state_d = IB;
         endcase
         O2: case (deb_q)
            2'b00: begin
               state_d  = IDLE;
               exited_d = 1'b1;
            end
            2'b11:   state_d = IB;
            2'b01:   state_d = ABORT;
            default: state_d = O2;
         endcase
         ABORT: begin
            if (deb_q == 2'b00) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // a stalled passage is abandoned even if it would complete on this edge
      if (state_q != IDLE && state_q != ABORT && tmo_q == TMO_LAST) begin
         state_d   = ABORT;
         entered_d = 1'b0;
         exited_d  = 1'b0;
      end

      if (state_d != state_q || state_q == IDLE || state_q == ABORT) begin
         tmo_d = '0;
      end else begin
         tmo_d = tmo_q + 8'd1;
      end

      fault_d = (state_d == ABORT);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         outer_sync_q <= '0;
         inner_sync_q <= '0;
         deb_q        <= '0;
         db_cnt_q     <= '0;
         state_q      <= IDLE;
         tmo_q        <= '0;
         entered_q    <= 1'b0;
         exited_q     <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         outer_sync_q <= {outer_sync_q[0], bus.outerBeam};
         inner_sync_q <= {inner_sync_q[0], bus.innerBeam};
         deb_q        <= deb_d;
         db_cnt_q     <= db_cnt_d;
         state_q      <= state_d;
         tmo_q        <= tmo_d;
         entered_q    <= entered_d;
         exited_q     <= exited_d;
         fault_q      <= fault_d;
      end
   end

   assign bus.entered = entered_q;
   assign bus.exited  = exited_q;
   assign bus.fault   = fault_q;

endmodule

// File: tb/tb_doorway_sensor.sv
// Bench for doorway_sensor: beam steps from a table push timed events to a
// scoreboard; a monitor pops and compares each pulse and fault edge it sees.
module tb_doorway_sensor;

   typedef enum int {EV_NONE, EV_ENT, EV_EXI, EV_FRISE, EV_FFALL} ev_e;

   typedef struct {
      logic o;
      logic i;
      int   hold;
      ev_e  ev;
      int   dly;
   } step_t;

   typedef struct {
      ev_e ev;
      int  cyc;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   logic fault_prev = 1'b0;
   exp_t  sb[$];
   step_t vec[$];

   doorway_sensor_if bus();

   doorway_sensor #(.DEBOUNCE(4), .TIMEOUT(64)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   function automatic step_t mk(input logic o, input logic i, input int hold,
                                input ev_e ev, input int dly);
      step_t s;
      s.o = o; s.i = i; s.hold = hold; s.ev = ev; s.dly = dly;
      return s;
   endfunction

   task automatic push_ev(input ev_e ev, input int at);
      exp_t e;
      e.ev = ev; e.cyc = at;
      sb.push_back(e);
   endtask

   // called just after a falling edge; returns just after a later falling edge
   task automatic drive(input step_t s);
      bus.outerBeam = s.o;
      bus.innerBeam = s.i;
      if (s.ev != EV_NONE) push_ev(s.ev, cyc + s.dly);
      repeat (s.hold) @(negedge clock);
   endtask

   task automatic expect_ev(input ev_e ev, input string nm);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL %s: saw %s at cycle %0d, required no event", nm, ev.name(), cyc);
      end else begin
         e = sb.pop_front();
         if (e.ev != ev || e.cyc != cyc) begin
            errors++;
            $display("FAIL %s: saw %s at cycle %0d, required %s at cycle %0d",
                     nm, ev.name(), cyc, e.ev.name(), e.cyc);
         end
      end
   endtask

   task automatic check_bit(input string nm, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %b, required %b", nm, act, req);
      end
   endtask

   initial begin
      int n;
      int len;
      bus.outerBeam = 1'b0;
      bus.innerBeam = 1'b0;

      // clean entry, clean exit, back-outs, simultaneous
      vec.push_back(mk(1, 0, 10, EV_NONE, 0));
      vec.push_back(mk(1, 1, 10, EV_NONE, 0));
      vec.push_back(mk(0, 1, 10, EV_NONE, 0));
      vec.push_back(mk(0, 0, 10, EV_ENT,  7));
      vec.push_back(mk(0, 1, 10, EV_NONE, 0));
      vec.push_back(mk(1, 1, 10, EV_NONE, 0));
      vec.push_back(mk(1, 0, 10, EV_NONE, 0));
      vec.push_back(mk(0, 0, 10, EV_EXI,  7));
      vec.push_back(mk(1, 0, 10, EV_NONE, 0));
      vec.push_back(mk(1, 1, 10, EV_NONE, 0));
      vec.push_back(mk(1, 0, 10, EV_NONE, 0));
      vec.push_back(mk(0, 0, 10, EV_NONE, 0));
      vec.push_back(mk(0, 1, 10, EV_NONE, 0));
      vec.push_back(mk(0, 0, 10, EV_NONE, 0));
      vec.push_back(mk(1, 1, 10, EV_FRISE, 7));
      vec.push_back(mk(0, 0, 10, EV_FFALL, 7));
      // each level held exactly DEBOUNCE cycles still counts
      vec.push_back(mk(1, 0, 4,  EV_NONE, 0));
      vec.push_back(mk(1, 1, 4,  EV_NONE, 0));
      vec.push_back(mk(0, 1, 4,  EV_NONE, 0));
      vec.push_back(mk(0, 0, 10, EV_ENT,  7));
      // a 3-cycle (0,1) glitch is ignored, otherwise it would abort
      vec.push_back(mk(1, 0, 10, EV_NONE, 0));
      vec.push_back(mk(0, 1, 3,  EV_NONE, 0));
      vec.push_back(mk(1, 0, 10, EV_NONE, 0));
      vec.push_back(mk(0, 0, 10, EV_NONE, 0));
      // longest O1 dwell that does not time out
      vec.push_back(mk(1, 0, 63, EV_NONE, 0));
      vec.push_back(mk(1, 1, 10, EV_NONE, 0));
      vec.push_back(mk(0, 1, 10, EV_NONE, 0));
      vec.push_back(mk(0, 0, 10, EV_ENT,  7));
      // outer held: O1 at +7, abort 64 edges later
      vec.push_back(mk(1, 0, 100, EV_FRISE, 71));
      vec.push_back(mk(0, 0, 10,  EV_FFALL, 7));

      #1 reset = 1'b0;
      #3;
      check_bit("reset_entered", bus.entered, 1'b0);
      check_bit("reset_exited",  bus.exited,  1'b0);
      check_bit("reset_fault",   bus.fault,   1'b0);
      repeat (3) @(negedge clock);
      reset = 1'b1;

      fork
         forever begin
            @(negedge clock);
            checks++;
            if (bus.entered === 1'b1 && bus.exited === 1'b1) begin
               errors++;
               $display("FAIL both_pulses: entered and exited high together at cycle %0d, required exclusive", cyc);
            end
            if (bus.entered === 1'b1) expect_ev(EV_ENT, "entered");
            if (bus.exited === 1'b1)  expect_ev(EV_EXI, "exited");
            if (bus.fault === 1'b1 && fault_prev === 1'b0) expect_ev(EV_FRISE, "fault_rise");
            if (bus.fault === 1'b0 && fault_prev === 1'b1) expect_ev(EV_FFALL, "fault_fall");
            fault_prev = bus.fault;
         end
      join_none

      repeat (2) @(negedge clock);
      for (int k = 0; k < vec.size(); k++) drive(vec[k]);

      // bounce on outer beam in runs of 1..3 cycles
      n = 0;
      while (n < 40) begin
         len = $urandom_range(1, 3);
         if (n + len > 40) len = 40 - n;
         bus.outerBeam = ~bus.outerBeam;
         repeat (len) @(negedge clock);
         n += len;
      end
      drive(mk(0, 0, 20, EV_NONE, 0));

      // reset while in OB, release with beams clear
      drive(mk(1, 0, 10, EV_NONE, 0));
      drive(mk(1, 1, 10, EV_NONE, 0));
      #2 reset = 1'b0;
      #1;
      check_bit("rst_ob_entered", bus.entered, 1'b0);
      check_bit("rst_ob_exited",  bus.exited,  1'b0);
      check_bit("rst_ob_fault",   bus.fault,   1'b0);
      bus.outerBeam = 1'b0;
      bus.innerBeam = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b1;
      repeat (50) @(negedge clock);

      // reset while in ABORT with beams still blocked through release
      drive(mk(1, 1, 10, EV_FRISE, 7));
      push_ev(EV_FFALL, cyc + 1);
      #2 reset = 1'b0;
      #1;
      check_bit("rst_abort_fault", bus.fault, 1'b0);
      repeat (2) @(negedge clock);
      #2 reset = 1'b1;
      push_ev(EV_FRISE, cyc + 7);
      repeat (10) @(negedge clock);
      drive(mk(0, 0, 20, EV_FFALL, 7));

      repeat (10) @(negedge clock);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL pending_events: %0d events never seen, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/doorway_sensor.md
DOORWAY_SENSOR -- requirements
Module: doorway_sensor

Interface
REQ-001 The block SHALL have parameter DEBOUNCE, default 4, meaning consecutive synchronized samples required to accept a beam level change (legal range 2..15).
REQ-002 The block SHALL have parameter TIMEOUT, default 64, meaning maximum cycles a passage may stay incomplete before abort (legal range 2..255).
REQ-003 The block SHALL have port clock, input, 1, the single rising-edge clock.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port outerBeam, input, 1, raw asynchronous street-side beam, 1 = blocked.
REQ-006 The block SHALL have port innerBeam, input, 1, raw asynchronous room-side beam, 1 = blocked.
REQ-007 The block SHALL have port entered, output, 1, one-cycle pulse per completed inward passage; it feeds the occupancy controller's entered input.
REQ-008 The block SHALL have port exited, output, 1, one-cycle pulse per completed outward passage; it feeds the occupancy controller's exited input.
REQ-009 The block SHALL have port fault, output, 1, high while an aborted passage waits for both beams to clear.

Function
REQ-010 Each beam SHALL pass through a two-flop synchronizer before any other logic.
REQ-011 Each channel SHALL keep a debounced level and a counter; counter clears when synced equals debounced, else increments.
REQ-012 When the counter equals DEBOUNCE-1 and synced still differs, the debounced level SHALL update on that edge and the counter SHALL clear.
REQ-013 A raw level held stable SHALL reach the debounced level on the (DEBOUNCE+2)th rising edge sampling it (6th edge at default).
REQ-014 Any synced run shorter than DEBOUNCE cycles SHALL leave the debounced level unchanged.
REQ-015 The direction FSM SHALL use debounced levels (o,i) and states IDLE, O1, OB, I2, I1, IB, O2, ABORT.
REQ-016 From IDLE: (1,0)->O1; (0,1)->I1; (1,1)->ABORT; (0,0)->stay.
REQ-017 Entry path: O1 (1,1)->OB, (0,0)->IDLE; OB (0,1)->I2, (1,0)->O1; I2 (0,0)->IDLE with entered, (1,1)->OB.
REQ-018 Exit path: I1 (1,1)->IB, (0,0)->IDLE; IB (1,0)->O2, (0,1)->I1; O2 (0,0)->IDLE with exited, (1,1)->IB.
REQ-019 Any (o,i) combination not listed for a non-IDLE, non-ABORT state SHALL go to ABORT.
REQ-020 ABORT SHALL hold until debounced (0,0), then go to IDLE, never issuing a pulse.
REQ-021 A timeout counter SHALL clear on every state change and count edges spent in any state other than IDLE or ABORT.
REQ-022 When the timeout counter reaches TIMEOUT, the FSM SHALL go to ABORT on that edge, overriding REQ-017/018.
REQ-023 entered and exited SHALL be registered, high exactly one cycle, asserting on the same edge as the completing transition.
REQ-024 entered and exited SHALL never be high in the same cycle; at most one pulse per passage.
REQ-025 fault SHALL be registered and equal (state == ABORT).
REQ-026 Backing out partway through a passage SHALL return toward IDLE without a pulse.

Reset
REQ-027 reset low SHALL immediately force synchronizers and debounced levels to 0, counters to 0, state IDLE, and entered, exited, fault to 0.
REQ-028 reset low mid-passage SHALL discard the passage; after release with beams still blocked, the FSM SHALL start from IDLE per REQ-016.
REQ-029 Reset release SHALL be synchronous to clock, with the first state update on the first edge after release.

Verification
REQ-030 Reset mid-passage: assert reset while in OB -> all outputs 0 at once; release with beams (0,0) -> no pulse for 50 cycles.
REQ-031 Clean entry, defaults: (1,0),(1,1),(0,1),(0,0), each held 10 cycles -> exactly one entered pulse on the 7th edge after the final raw change; exited and fault stay 0.
REQ-032 Clean exit: (0,1),(1,1),(1,0),(0,0), each held 10 cycles -> exactly one exited pulse; entered stays 0.
REQ-033 Bounce: outerBeam toggles in runs of 1-3 cycles for 40 cycles, then 0 -> debounced level stays 0, FSM stays IDLE, no pulses.
REQ-034 Back-out and simultaneous: (1,0),(1,1),(1,0),(0,0) -> no pulse; both beams rise on the same cycle -> fault high until 7 edges after both clear, no pulse.
REQ-035 Timeout: outerBeam held 1 for 100 cycles -> fault asserts exactly 64 edges after the FSM enters O1, clears after beam release plus debounce, no pulse.
